dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, address width; TIMEOUT_CYCLES, 16, access watchdog limit (used only with the timeout feature).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- core_req / core_we  in  1  core load/store request / write.
- core_addr  in  ADDR_WIDTH  core address.
- core_wdata  in  DATA_WIDTH  core store data.
- core_rdata  out  DATA_WIDTH  core load data.
- core_stall  out  1  freezes PC and register-file write.
- ld_req / ld_we  in  1  loader request / write.
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_gnt  out  1  loader grant pulse.
- ld_rvalid  out  1  loader completion pulse.
- ld_rdata  out  DATA_WIDTH  loader read data.
- mem_en / mem_we  out  1  memory access / write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_ready  in  1  memory access complete this cycle.
- err  out  1  access-abort pulse.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, CORE_ACC and LD_ACC.
REQ-004 In IDLE with exactly one requester active, that requester SHALL be granted at the next edge.
REQ-005 In IDLE with both requesters active, the requester not recorded in last_gnt SHALL win; last_gnt SHALL update on every grant.
REQ-006 At the grant edge, mem_addr, mem_we and mem_wdata SHALL be registered from the granted requester, and mem_en SHALL be set.
REQ-007 mem_en SHALL stay high for the whole of CORE_ACC and LD_ACC, and mem_* outputs SHALL be stable throughout an access.
REQ-008 ld_gnt SHALL be a one-cycle registered pulse in the first LD_ACC cycle.
REQ-009 Completion SHALL be the ACC cycle where mem_ready=1.
- The next edge returns to IDLE and clears mem_en and mem_we.
- Minimum access is 2 cycles (grant edge plus one ACC cycle), followed by one mandatory IDLE cycle.
REQ-010 core_stall SHALL be combinational: core_req AND NOT (state==CORE_ACC AND mem_ready).
REQ-011 core_rdata SHALL pass mem_rdata through combinationally; it is valid only in the CORE_ACC completion cycle.
REQ-012 On loader completion, ld_rdata SHALL register mem_rdata and ld_rvalid SHALL pulse high for one cycle, one cycle after completion.
REQ-013 ld_rdata SHALL hold its value until the next loader completion.
REQ-014 A requester deasserting its req mid-access SHALL NOT abort the access; it completes and its result is discarded.
REQ-015 mem_ready while in IDLE SHALL be ignored.
REQ-016 A new req arriving during an access SHALL wait; it is arbitrated only in IDLE.

Reset
REQ-017 reset_n low SHALL immediately force IDLE, regardless of edge or in-flight access; the in-flight access is dropped with no completion signalling.
REQ-018 Reset values SHALL be:
- state=IDLE, last_gnt=loader (core wins the first tie).
- mem_en, mem_we, ld_gnt, ld_rvalid, err = 0.
- mem_addr, mem_wdata, ld_rdata = 0; timeout counter = 0.
- core_stall = core_req.

Configuration
REQ-019 With macro DMEM_ARB_TIMEOUT_EN defined:
- A counter SHALL count ACC cycles without mem_ready.
- Abort SHALL occur in the ACC cycle where the count reaches TIMEOUT_CYCLES.
- On abort: err pulses one cycle; core_stall drops with core_rdata=0 (core access), or ld_rvalid pulses with ld_rdata=0 (loader access).
- The FSM then returns to IDLE.
REQ-020 Without DMEM_ARB_TIMEOUT_EN, accesses SHALL wait indefinitely for mem_ready, err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-021 Core read:
- Stimulus: core_req=1, core_we=0, core_addr=0x100; mem_ready=1 on the first ACC cycle with mem_rdata=0xDEADBEEF.
- Response: core_stall=1 for 1 cycle then 0; core_rdata=0xDEADBEEF on the completion cycle; mem_en high exactly 1 cycle.
REQ-022 Simultaneous requests from reset:
- Stimulus: core and loader requests held high for three accesses.
- Response: grant order core, loader, core; ld_gnt pulses once.
REQ-023 Loader write with wait states:
- Stimulus: ld_we=1, ld_addr=0x40, ld_wdata=0x12345678; mem_ready delayed 3 cycles.
- Response: mem_addr=0x40 and mem_wdata=0x12345678 stable for all 4 ACC cycles; ld_rvalid pulses one cycle after ready.
REQ-024 Reset mid-access:
- Stimulus: reset_n=0 during LD_ACC before mem_ready.
- Response: mem_en=0 immediately; no ld_rvalid; first post-reset tie goes to the core.
REQ-025 Timeout (DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
- Stimulus: core read with mem_ready held 0.
- Response: err pulse in the 4th ACC cycle; core_stall low that cycle with core_rdata=0; IDLE next cycle.
REQ-026 Ignored ready:
- Stimulus: mem_ready=1 while IDLE with no requests.
- Response: no state change; all outputs remain at reset values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// The CPU core and a program loader share one memory port. Ties go to whichever
// requester was not granted last, and an access holds the port until the memory
// reports mem_ready. One IDLE cycle always separates two accesses.
//
// Ports
//   clk, reset_n                : clock, asynchronous active-low reset
//   core_req/we/addr/wdata      : core request channel
//   core_rdata, core_stall      : core load data (combinational) and pipeline stall
//   ld_req/we/addr/wdata        : loader request channel
//   ld_gnt, ld_rvalid, ld_rdata : loader grant pulse, completion pulse, read data
//   mem_en/we/addr/wdata        : registered memory request, stable during an access
//   mem_rdata, mem_ready        : memory response
//   err                         : access-abort pulse (timeout builds only)
//
// Optional feature: define DMEM_ARB_TIMEOUT_EN to enable an access watchdog that
// aborts an access after TIMEOUT_CYCLES access cycles without mem_ready.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StCoreAcc, StLdAcc} state_e;

  state_e                state_q, state_d;
  logic                  last_ld_q, last_ld_d;  // 1: loader was granted last
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  ld_gnt_q, ld_gnt_d;
  logic                  ld_rvalid_q, ld_rvalid_d;
  logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

  logic in_acc;
  logic timeout;
  logic done;

  assign in_acc = (state_q != StIdle);

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CntW-1:0] to_cnt_q, to_cnt_d;

  // to_cnt_q holds the number of earlier ready-less cycles of this access, so the
  // abort lands in the cycle where the running count reaches TIMEOUT_CYCLES.
  assign timeout  = in_acc && !mem_ready && (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d = (in_acc && !mem_ready && !timeout) ? to_cnt_q + 1'b1 : '0;
  assign err      = timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
  assign err                   = 1'b0;
`endif

  // An access ends on mem_ready or on a watchdog abort.
  assign done = in_acc && (mem_ready || timeout);

  always_comb begin
    state_d     = state_q;
    last_ld_d   = last_ld_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_gnt_d    = 1'b0;
    ld_rvalid_d = 1'b0;
    ld_rdata_d  = ld_rdata_q;

    unique case (state_q)
      StIdle: begin
        // mem_ready is deliberately ignored here.
        if (core_req && (!ld_req || last_ld_q)) begin
          state_d     = StCoreAcc;
          last_ld_d   = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = core_we;
          mem_addr_d  = core_addr;
          mem_wdata_d = core_wdata;
        end else if (ld_req) begin
          state_d     = StLdAcc;
          last_ld_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = ld_we;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
          ld_gnt_d    = 1'b1;
        end
      end
      StCoreAcc: begin
        if (done) begin
          state_d  = StIdle;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      StLdAcc: begin
        if (done) begin
          state_d     = StIdle;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          ld_rvalid_d = 1'b1;
          ld_rdata_d  = timeout ? '0 : mem_rdata;
        end
      end
      default: begin
        state_d  = StIdle;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      last_ld_q   <= 1'b1;  // core wins the first tie
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_gnt_q    <= 1'b0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_ld_q   <= last_ld_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_gnt_q    <= ld_gnt_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // The core is released in its completion cycle, so data is taken straight
  // from the memory; an aborted core access returns zero.
  assign core_stall = core_req && !((state_q == StCoreAcc) && (mem_ready || timeout));
  assign core_rdata = ((state_q == StCoreAcc) && timeout) ? '0 : mem_rdata;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_gnt    = ld_gnt_q;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (default build, no timeout feature).
// A responder models the memory with a programmable number of wait states; the
// stimulus pushes expected grants and loader read data, and a negedge monitor
// pops and compares them as the design produces them.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          core_req, core_we, ld_req, ld_we;
  logic [AW-1:0] core_addr, ld_addr;
  logic [DW-1:0] core_wdata, ld_wdata;
  logic [DW-1:0] core_rdata, ld_rdata;
  logic          core_stall, ld_gnt, ld_rvalid;
  logic          mem_en, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  typedef struct {
    logic          who;   // 1: loader
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            len;   // expected ACC cycles, 0: not checked
  } gnt_t;

  gnt_t          gnt_q[$];
  logic [DW-1:0] ld_exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_gnt(input logic who, input logic [AW-1:0] addr, input logic we,
                          input logic [DW-1:0] wdata, input int len);
    gnt_t g;
    g.who   = who;
    g.addr  = addr;
    g.we    = we;
    g.wdata = wdata;
    g.len   = len;
    gnt_q.push_back(g);
  endtask

  // Memory responder: ready after 'lat' wait states, returning rd_data.
  int            lat        = 0;
  int            rcnt       = 0;
  logic          idle_ready = 1'b0;
  logic [DW-1:0] rd_data    = '0;

  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      mem_ready = (rcnt == lat);
      mem_rdata = mem_ready ? rd_data : '0;
      rcnt++;
    end else begin
      rcnt      = 0;
      mem_ready = idle_ready;
      mem_rdata = '0;
    end
  end

  // Monitor / scoreboard.
  logic          en_prev = 1'b0;
  logic          rv_pend = 1'b0;
  logic [DW-1:0] last_ld = '0;
  int            acc_len = 0;
  int            gnt_cnt = 0;
  gnt_t          cur;

  always @(negedge clk) begin
    if (!reset_n) begin
      en_prev = 1'b0;
      rv_pend = 1'b0;
      last_ld = '0;
    end else begin
      check_eq("ld_rvalid", ld_rvalid, rv_pend);
      if (rv_pend) begin
        check_eq("ld_exp_avail", ld_exp_q.size() > 0, 1);
        if (ld_exp_q.size() > 0) last_ld = ld_exp_q.pop_front();
        check_eq("ld_rdata", ld_rdata, last_ld);
      end else begin
        check_eq("ld_rdata_hold", ld_rdata, last_ld);
      end
      rv_pend = 1'b0;

      if (mem_en && !en_prev) begin
        gnt_cnt++;
        acc_len = 0;
        check_eq("grant_expected", gnt_q.size() > 0, 1);
        if (gnt_q.size() > 0) cur = gnt_q.pop_front();
        check_eq("grant_who", ld_gnt, cur.who);
        check_eq("grant_addr", mem_addr, cur.addr);
        check_eq("grant_we", mem_we, cur.we);
        check_eq("grant_wdata", mem_wdata, cur.wdata);
      end else begin
        check_eq("ld_gnt_pulse", ld_gnt, 0);
        if (mem_en) begin
          check_eq("stable_addr", mem_addr, cur.addr);
          check_eq("stable_wdata", mem_wdata, cur.wdata);
          check_eq("stable_we", mem_we, cur.we);
        end else begin
          check_eq("idle_we", mem_we, 0);
        end
      end

      if (mem_en) begin
        acc_len++;
        if (mem_ready) begin
          if (cur.who) begin
            rv_pend = 1'b1;
          end else begin
            check_eq("core_stall_done", core_stall, 0);
            check_eq("core_rdata", core_rdata, rd_data);
          end
          if (cur.len != 0) check_eq("acc_len", acc_len, cur.len);
        end
      end
      check_eq("err_tied", err, 0);
      en_prev = mem_en;
    end
  end

  task automatic wait_grants(input int target);
    int n = 0;
    while (gnt_cnt < target && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("grant_wait", gnt_cnt >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check_eq("rst_stall_req1", core_stall, 1);
    core_req = 1'b0;
    #1;
    check_eq("rst_stall_req0", core_stall, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_ld_gnt", ld_gnt, 0);
    check_eq("rst_ld_rvalid", ld_rvalid, 0);
    check_eq("rst_ld_rdata", ld_rdata, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // mem_ready while idle with no requests is ignored.
    @(negedge clk);
    idle_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_rdy_en", mem_en, 0);
    check_eq("idle_rdy_addr", mem_addr, 0);
    check_eq("idle_rdy_rvalid", ld_rvalid, 0);
    idle_ready = 1'b0;

    // Simultaneous requests from reset: core, loader, core.
    @(posedge clk);
    #2;
    lat     = 1;
    rd_data = 32'hA5A5_0001;
    push_gnt(1'b0, 32'h200, 1'b1, 32'h1111_0000, 2);
    push_gnt(1'b1, 32'h300, 1'b0, 32'h0, 2);
    push_gnt(1'b0, 32'h200, 1'b1, 32'h1111_0000, 2);
    ld_exp_q.push_back(32'hA5A5_0001);
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'h1111_0000;
    ld_req   = 1'b1; ld_we   = 1'b0; ld_addr   = 32'h300; ld_wdata   = '0;
    wait_grants(3);
    core_req = 1'b0;
    ld_req   = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    // Core read, single-cycle memory.
    lat     = 0;
    rd_data = 32'hDEAD_BEEF;
    push_gnt(1'b0, 32'h100, 1'b0, 32'h0, 1);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_wdata = '0;
    @(negedge clk);
    check_eq("core_stall_idle", core_stall, 1);
    check_eq("core_en_idle", mem_en, 0);
    wait_grants(4);
    core_req = 1'b0;
    @(negedge clk);
    check_eq("core_en_after", mem_en, 0);
    repeat (2) @(posedge clk);
    #2;

    // Loader write with three wait states.
    lat     = 3;
    rd_data = 32'h0BAD_F00D;
    push_gnt(1'b1, 32'h40, 1'b1, 32'h1234_5678, 4);
    ld_exp_q.push_back(32'h0BAD_F00D);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'h1234_5678;
    wait_grants(5);
    ld_req = 1'b0;
    repeat (7) @(posedge clk);
    #2;

    // Reset in the middle of a loader access.
    lat     = 10;
    push_gnt(1'b1, 32'h80, 1'b0, 32'h0, 0);
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h80; ld_wdata = '0;
    wait_grants(6);
    check_eq("pre_rst_en", mem_en, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_en", mem_en, 0);
    check_eq("mid_rst_we", mem_we, 0);
    lat     = 0;
    rd_data = 32'h0000_0077;
    push_gnt(1'b0, 32'h500, 1'b0, 32'h0, 1);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h500; core_wdata = '0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    wait_grants(7);
    core_req = 1'b0;
    ld_req   = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    check_eq("grants_left", gnt_q.size(), 0);
    check_eq("ld_data_left", ld_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
